// File: rtl/ibex_fetch_req_ctrl.sv
// Request-side controller for the instruction fetch FIFO: issues word-aligned bus
// fetches, tracks outstanding responses and drops the ones made stale by a branch.
//
// state    | meaning
// IDLE     | no request held; may start one combinationally this cycle
// WAIT_GNT | request issued without grant; address frozen until gnt
module ibex_fetch_req_ctrl #(
   parameter int unsigned NUM_REQS = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         branch_addr_i,
   output logic                busy_o,
   output logic                fifo_clear_o,
   input  logic [NUM_REQS-1:0] fifo_busy_i,
   output logic                fifo_valid_o,
   output logic [31:0]         fifo_addr_o,
   output logic [31:0]         fifo_rdata_o,
   output logic                fifo_err_o,
   output logic                instr_req_o,
   input  logic                instr_gnt_i,
   output logic [31:0]         instr_addr_o,
   input  logic                instr_rvalid_i,
   input  logic [31:0]         instr_rdata_i,
   input  logic                instr_err_i
);

   typedef enum logic {IDLE, WAIT_GNT} state_e;

   state_e              state_q, state_d;
   logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
   logic [NUM_REQS-1:0] discard_q, discard_d;
   logic [NUM_REQS-1:0] out_rev, out_shift, disc_shift, new_bit;
   logic [31:0]         fetch_addr_q, fetch_addr_d;
   logic [31:0]         stored_addr_q, stored_addr_d;
   logic [31:0]         branch_tgt, req_addr;
   logic                branch_pend_q, branch_pend_d;
   logic                slot_free, start_ok, grant, pre_branch;

   always_comb begin
      out_rev = '0;
      for (int i = 0; i < int'(NUM_REQS); i++) begin
         out_rev[i] = outstanding_q[int'(NUM_REQS)-1-i];
      end
   end

   assign branch_tgt = {branch_addr_i[31:2], 2'b00};
   assign slot_free  = ~&(fifo_busy_i | out_rev);
   assign start_ok   = req_i & slot_free & ~outstanding_q[NUM_REQS-1];

   always_comb begin
      state_d       = state_q;
      stored_addr_d = stored_addr_q;
      instr_req_o   = 1'b0;
      req_addr      = fetch_addr_q;
      pre_branch    = 1'b0;
      case (state_q)
         IDLE: begin
            instr_req_o = start_ok;
            req_addr    = branch_i ? branch_tgt : fetch_addr_q;
            if (start_ok && !instr_gnt_i) begin
               state_d       = WAIT_GNT;
               stored_addr_d = req_addr;
            end
         end
         WAIT_GNT: begin
            instr_req_o = 1'b1;
            req_addr    = stored_addr_q;
            // the held address was computed before any branch seen since
            pre_branch  = branch_pend_q | branch_i;
            if (instr_gnt_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign instr_addr_o = req_addr;
   assign grant        = instr_req_o & instr_gnt_i;

   always_comb begin
      out_shift  = instr_rvalid_i ? (outstanding_q >> 1) : outstanding_q;
      disc_shift = instr_rvalid_i ? (discard_q >> 1) : discard_q;
      if (branch_i) begin
         disc_shift = disc_shift | out_shift;
      end
      // lowest clear bit of the post-retire vector
      new_bit       = ~out_shift & (out_shift + NUM_REQS'(1));
      outstanding_d = out_shift | (grant ? new_bit : '0);
      discard_d     = disc_shift | ((grant && pre_branch) ? new_bit : '0);

      fetch_addr_d = fetch_addr_q;
      if (grant) begin
         if (pre_branch) begin
            fetch_addr_d = branch_i ? branch_tgt : fetch_addr_q;
         end else begin
            fetch_addr_d = req_addr + 32'd4;
         end
      end else if (branch_i) begin
         fetch_addr_d = branch_tgt;
      end

      branch_pend_d = branch_pend_q;
      if (grant) begin
         branch_pend_d = 1'b0;
      end else if (branch_i && state_q == WAIT_GNT) begin
         branch_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         outstanding_q <= '0;
         discard_q     <= '0;
         fetch_addr_q  <= '0;
         stored_addr_q <= '0;
         branch_pend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         fetch_addr_q  <= fetch_addr_d;
         stored_addr_q <= stored_addr_d;
         branch_pend_q <= branch_pend_d;
      end
   end

   assign fifo_clear_o = branch_i;
   assign fifo_addr_o  = branch_i ? branch_addr_i : fetch_addr_q;
   assign fifo_valid_o = instr_rvalid_i & outstanding_q[0] & ~discard_q[0] & ~branch_i;
   assign fifo_rdata_o = instr_rdata_i;
   assign fifo_err_o   = instr_err_i;
   assign busy_o       = (|outstanding_q) | instr_req_o;

   a_rvalid_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
      instr_rvalid_i |-> (|outstanding_q));
   a_push_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (fifo_valid_o && !fifo_clear_o) |-> !fifo_busy_i[NUM_REQS-1]);
   a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Bench for ibex_fetch_req_ctrl: directed scenarios plus random traffic against a
// queue-based model of the outstanding responses.
module tb_ibex_fetch_req_ctrl;
   localparam int NR = 2;

   logic          clk = 1'b0;
   logic          rst_ni, req_i, branch_i, busy_o, fifo_clear_o, fifo_valid_o, fifo_err_o;
   logic [31:0]   branch_addr_i, fifo_addr_o, fifo_rdata_o, instr_addr_o, instr_rdata_i;
   logic [NR-1:0] fifo_busy_i;
   logic          instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;

   int total = 0;
   int bad   = 0;

   ibex_fetch_req_ctrl #(.NUM_REQS(NR)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i),
      .branch_addr_i(branch_addr_i), .busy_o(busy_o), .fifo_clear_o(fifo_clear_o),
      .fifo_busy_i(fifo_busy_i), .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o),
      .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o), .instr_req_o(instr_req_o),
      .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
      .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
      .instr_err_i(instr_err_i)
   );

   always #5 clk = ~clk;

   // Model: a queue of in-flight fetches, each remembering whether it is stale.
   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } ent_t;
   ent_t        q[$];
   logic [31:0] m_fetch, m_held_addr;
   bit          m_held, m_bpend;
   bit          exp_req, exp_valid, exp_busy;
   logic [31:0] exp_addr, exp_faddr;

   function automatic logic [31:0] align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   function automatic void model_reset();
      q.delete();
      m_fetch = 0; m_held_addr = 0; m_held = 0; m_bpend = 0;
   endfunction

   function automatic void model_eval();
      int  n = q.size();
      bit  room = 0;
      for (int j = 0; j < NR - n; j++) if (!fifo_busy_i[j]) room = 1;
      if (m_held) begin
         exp_req = 1; exp_addr = m_held_addr;
      end else begin
         exp_req  = req_i && room && (n < NR);
         exp_addr = branch_i ? align(branch_addr_i) : m_fetch;
      end
      exp_valid = instr_rvalid_i && (n > 0) && !branch_i && !q[0].stale;
      exp_faddr = branch_i ? branch_addr_i : m_fetch;
      exp_busy  = (n > 0) || exp_req;
   endfunction

   function automatic void model_update();
      bit   gr, pre;
      ent_t e;
      if (!rst_ni) begin
         model_reset();
         return;
      end
      gr  = exp_req && instr_gnt_i;
      pre = m_held && (m_bpend || branch_i);
      if (instr_rvalid_i && q.size() > 0) void'(q.pop_front());
      if (branch_i) foreach (q[i]) q[i].stale = 1;
      if (gr) begin
         e.addr = exp_addr; e.stale = pre;
         q.push_back(e);
         if (!pre) m_fetch = exp_addr + 32'd4;
         else if (branch_i) m_fetch = align(branch_addr_i);
         m_held = 0; m_bpend = 0;
      end else begin
         if (branch_i) begin
            m_fetch = align(branch_addr_i);
            if (m_held) m_bpend = 1;
         end
         if (exp_req && !m_held) begin
            m_held = 1; m_held_addr = exp_addr;
         end
      end
   endfunction

   task automatic drive(input bit rst, input bit rq, input bit br, input logic [31:0] ba,
                        input logic [NR-1:0] fb, input bit gn, input bit rv,
                        input logic [31:0] rd, input bit er);
      rst_ni = rst; req_i = rq; branch_i = br; branch_addr_i = ba; fifo_busy_i = fb;
      instr_gnt_i = gn; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
      model_eval();
      @(negedge clk);
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 32'h1234, 0);
      total++; if ({instr_req_o, fifo_valid_o, fifo_clear_o, busy_o} !== 4'b0) begin
         bad++; $display("FAIL reset_outs got=%b exp=0000",
                         {instr_req_o, fifo_valid_o, fifo_clear_o, busy_o});
      end
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (fifo_addr_o !== 32'h0) begin
         bad++; $display("FAIL reset_fetch got=%h exp=0", fifo_addr_o);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 1, 32'h80, 0, 1, 0, 0, 0);
      total++; if ({instr_req_o, fifo_clear_o} !== 2'b11 || instr_addr_o !== 32'h80) begin
         bad++; $display("FAIL b2b_first got=%b/%h exp=11/00000080",
                         {instr_req_o, fifo_clear_o}, instr_addr_o);
      end
      tick();
      drive(1, 1, 0, 0, 0, 1, 1, 32'hAAAA_0080, 0);
      total++; if (instr_addr_o !== 32'h84 || !instr_req_o || fifo_clear_o) begin
         bad++; $display("FAIL b2b_second got=%h req=%b clr=%b exp=00000084 1 0",
                         instr_addr_o, instr_req_o, fifo_clear_o);
      end
      total++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hAAAA_0080) begin
         bad++; $display("FAIL b2b_push0 got=%b/%h exp=1/aaaa0080", fifo_valid_o, fifo_rdata_o);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0, 1, 32'hAAAA_0084, 0);
      total++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hAAAA_0084) begin
         bad++; $display("FAIL b2b_push1 got=%b/%h exp=1/aaaa0084", fifo_valid_o, fifo_rdata_o);
      end
      tick();
   endtask

   task automatic test_gnt_stall_branch();
      drive(1, 0, 1, 32'h100, 0, 0, 0, 0, 0); tick();
      for (int c = 0; c < 4; c++) begin
         drive(1, 1, (c == 1), 32'h202, 0, (c == 3), 0, 0, 0);
         total++; if (!instr_req_o || instr_addr_o !== 32'h100) begin
            bad++; $display("FAIL stall_addr c=%0d got=%b/%h exp=1/00000100",
                            c, instr_req_o, instr_addr_o);
         end
         if (c == 1) begin
            total++; if (!fifo_clear_o || fifo_addr_o !== 32'h202) begin
               bad++; $display("FAIL stall_clear got=%b/%h exp=1/00000202",
                               fifo_clear_o, fifo_addr_o);
            end
         end
         tick();
      end
      drive(1, 1, 0, 0, 0, 0, 1, 32'h5555_0100, 0);
      total++; if (fifo_valid_o !== 1'b0 || !instr_req_o || instr_addr_o !== 32'h200) begin
         bad++; $display("FAIL stall_drop got=%b/%b/%h exp=0/1/00000200",
                         fifo_valid_o, instr_req_o, instr_addr_o);
      end
      tick();
      drive(1, 1, 0, 0, 0, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 1, 32'h5555_0200, 0);
      total++; if (fifo_valid_o !== 1'b1) begin
         bad++; $display("FAIL stall_push got=%b exp=1", fifo_valid_o);
      end
      tick();
   endtask

   task automatic test_branch_outstanding();
      drive(1, 0, 1, 32'h40, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 1, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
      total++; if (instr_addr_o !== 32'h44) begin
         bad++; $display("FAIL br_second got=%h exp=00000044", instr_addr_o);
      end
      tick();
      drive(1, 1, 1, 32'h300, 0, 1, 0, 0, 0);
      total++; if (instr_req_o !== 1'b0) begin
         bad++; $display("FAIL br_full got=%b exp=0", instr_req_o);
      end
      tick();
      drive(1, 1, 0, 0, 0, 1, 1, 32'h40, 0);
      total++; if ({fifo_valid_o, instr_req_o} !== 2'b00) begin
         bad++; $display("FAIL br_drop0 got=%b exp=00", {fifo_valid_o, instr_req_o});
      end
      tick();
      drive(1, 1, 0, 0, 0, 1, 1, 32'h44, 0);
      total++; if (fifo_valid_o !== 1'b0 || !instr_req_o || instr_addr_o !== 32'h300) begin
         bad++; $display("FAIL br_drop1 got=%b/%b/%h exp=0/1/00000300",
                         fifo_valid_o, instr_req_o, instr_addr_o);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0, 1, 32'h300, 0);
      total++; if (fifo_valid_o !== 1'b1) begin
         bad++; $display("FAIL br_push got=%b exp=1", fifo_valid_o);
      end
      tick();
   endtask

   task automatic test_fifo_busy();
      for (int c = 0; c < 3; c++) begin
         drive(1, 1, 0, 0, 2'b11, 1, 0, 0, 0);
         total++; if (instr_req_o !== 1'b0) begin
            bad++; $display("FAIL busy_block c=%0d got=%b exp=0", c, instr_req_o);
         end
         tick();
      end
      drive(1, 1, 0, 0, 2'b01, 1, 0, 0, 0);
      total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h304) begin
         bad++; $display("FAIL busy_one got=%b/%h exp=1/00000304", instr_req_o, instr_addr_o);
      end
      tick();
      drive(1, 1, 0, 0, 2'b01, 1, 0, 0, 0);
      total++; if (instr_req_o !== 1'b0) begin
         bad++; $display("FAIL busy_only_one got=%b exp=0", instr_req_o);
      end
      tick();
      drive(1, 0, 0, 0, 2'b01, 0, 1, 32'h304, 0); tick();
   endtask

   task automatic test_err_and_branch_rvalid();
      drive(1, 1, 0, 0, 0, 1, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 1);
      total++; if ({fifo_valid_o, fifo_err_o} !== 2'b11 || fifo_rdata_o !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL err_push got=%b/%h exp=11/deadbeef",
                         {fifo_valid_o, fifo_err_o}, fifo_rdata_o);
      end
      tick();
      drive(1, 0, 1, 32'h600, 0, 0, 1, 32'h1, 0);
      total++; if (fifo_valid_o !== 1'b0 || !fifo_clear_o) begin
         bad++; $display("FAIL br_rvalid got=%b clr=%b exp=0 1", fifo_valid_o, fifo_clear_o);
      end
      tick();
   endtask

   task automatic test_reset_midflight_wrap();
      drive(1, 0, 1, 32'h500, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 1, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 1, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 32'h500, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 32'h504, 0);
      total++; if ({instr_req_o, fifo_valid_o, fifo_clear_o, busy_o} !== 4'b0) begin
         bad++; $display("FAIL mid_reset got=%b exp=0000",
                         {instr_req_o, fifo_valid_o, fifo_clear_o, busy_o});
      end
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (fifo_addr_o !== 32'h0 || busy_o !== 1'b0) begin
         bad++; $display("FAIL mid_reset_fetch got=%h/%b exp=0/0", fifo_addr_o, busy_o);
      end
      tick();
      drive(1, 1, 1, 32'hFFFF_FFFE, 0, 1, 0, 0, 0);
      total++; if (instr_addr_o !== 32'hFFFF_FFFC || fifo_addr_o !== 32'hFFFF_FFFE) begin
         bad++; $display("FAIL wrap_first got=%h/%h exp=fffffffc/fffffffe",
                         instr_addr_o, fifo_addr_o);
      end
      tick();
      drive(1, 1, 0, 0, 0, 1, 1, 32'h7, 0);
      total++; if (instr_addr_o !== 32'h0 || !instr_req_o) begin
         bad++; $display("FAIL wrap_next got=%h/%b exp=00000000/1", instr_addr_o, instr_req_o);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0, 1, 32'h8, 0); tick();
   endtask

   task automatic test_random();
      logic [NR-1:0] fb;
      for (int c = 0; c < 1500; c++) begin
         fb = NR'($urandom);
         fb[NR-1] = 1'b0;
         drive(1, ($urandom_range(9) < 8), ($urandom_range(11) == 0),
               $urandom & 32'hFFFF_FFFE, fb, $urandom_range(1) == 1,
               (q.size() > 0) && ($urandom_range(1) == 1), $urandom, $urandom_range(1) == 1);
         total++; if (instr_req_o !== exp_req) begin
            bad++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, instr_req_o, exp_req);
         end
         if (exp_req) begin
            total++; if (instr_addr_o !== exp_addr) begin
               bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, instr_addr_o, exp_addr);
            end
         end
         total++; if (fifo_valid_o !== exp_valid || busy_o !== exp_busy) begin
            bad++; $display("FAIL rnd_valid_busy c=%0d got=%b%b exp=%b%b",
                            c, fifo_valid_o, busy_o, exp_valid, exp_busy);
         end
         total++; if (fifo_clear_o !== branch_i || fifo_addr_o !== exp_faddr) begin
            bad++; $display("FAIL rnd_fifo_addr c=%0d got=%b/%h exp=%b/%h",
                            c, fifo_clear_o, fifo_addr_o, branch_i, exp_faddr);
         end
         if (exp_valid) begin
            total++; if (fifo_rdata_o !== instr_rdata_i || fifo_err_o !== instr_err_i) begin
               bad++; $display("FAIL rnd_data c=%0d got=%h/%b exp=%h/%b",
                               c, fifo_rdata_o, fifo_err_o, instr_rdata_i, instr_err_i);
            end
         end
         tick();
      end
   endtask

   initial begin
      model_reset();
      rst_ni = 0; req_i = 0; branch_i = 0; branch_addr_i = 0; fifo_busy_i = 0;
      instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
      @(posedge clk); #1;
      test_reset();
      test_back_to_back();
      test_gnt_stall_branch();
      test_branch_outstanding();
      test_fifo_busy();
      test_err_and_branch_rvalid();
      test_reset_midflight_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
